wb_mem_responder: RTL
=====================

# wb_mem_responder

Wishbone classic slave backing a 16-bit word-addressed on-chip memory. It answers the 8-beat line refills issued by the instruction cache and also serves data-side reads and writes. It sits on the instruction or data bus behind the arbiter and gives one `wb_ack` or `wb_err` per strobed beat. Programmable wait states model slow memory, and an optional sequential prefetch buffer speeds up line bursts.

## Interface
Parameters:
- `DEPTH_LOG2`, 10: memory holds 2**DEPTH_LOG2 16-bit words at word addresses 0..2**DEPTH_LOG2-1.
- `WAIT_STATES`, 2: extra cycles between request acceptance and ack for a non-prefetched access; legal range 0..15.

Ports:
- `i_clk`  in  1: the single clock; all logic on its rising edge.
- `i_rst`  in  1: synchronous, active-high reset.
- `wb_cyc`  in  1: bus cycle active.
- `wb_stb`  in  1: strobe; the master holds it high across burst beats.
- `wb_adr`  in  16: word address; changes only after an ack or err.
- `wb_we`  in  1: 1 = write.
- `wb_sel`  in  2: byte enables; bit1 = [15:8], bit0 = [7:0].
- `wb_i_dat`  in  16: write data from master.
- `wb_o_dat`  out  16: read data to master; registered.
- `wb_ack`  out  1: beat complete; registered, one-cycle pulse.
- `wb_err`  out  1: beat failed; registered, one-cycle pulse, exclusive with `wb_ack`.

## Operation
- FSM states:
  - IDLE: ack/err low. If `wb_cyc & wb_stb`, latch adr, we, sel, dat; an out-of-range adr → ERR, prefetch hit → ACK, else → WAIT with counter = WAIT_STATES.
  - WAIT: counter decrements each cycle; at 0, memory access is performed and state → ACK. With WAIT_STATES=0, WAIT lasts exactly one cycle, the synchronous memory read.
  - ACK: `wb_ack`=1 for one cycle; → IDLE.
  - ERR: `wb_err`=1 for one cycle; → IDLE.
- Out of range means `wb_adr[15:DEPTH_LOG2]` != 0. On ERR: no memory access, `wb_o_dat` and prefetch state unchanged.
- Reads: `wb_o_dat` is loaded with mem[adr] on entry to ACK and holds until the next read ack.
- Writes:
  - Commit on entry to ACK, per byte enable; `wb_sel`=00 acks with no change.
  - `wb_o_dat` is unchanged by writes.
  - Any committed write invalidates the prefetch buffer.
- Abort: `wb_cyc` low while in WAIT → IDLE next cycle, no ack, no write. `wb_ack`/`wb_err` are gated by `wb_cyc`.
- Reset: outputs 0, FSM IDLE, prefetch invalid. Memory contents are not reset. Reset in WAIT drops the beat with no write.

## Timing
- Request sampled in IDLE at cycle T (not a prefetch hit): ack at T+2+WAIT_STATES; IDLE again at T+3+WAIT_STATES.
- Out-of-range request at T: err at T+1.
- Prefetch hit at T: ack at T+1.
- Back-to-back beats: the next beat is sampled in the IDLE cycle after ack. A stale address is never re-acked because ack is never high in IDLE.

## Configuration
- Macro `WB_RESP_PREFETCH_EN`.
- Defined:
  - During a read ACK of address A with A+1 in range, mem[A+1] is loaded into a one-entry buffer (tag A+1, valid).
  - An IDLE read request whose address equals the tag, with the buffer valid, is a hit: → ACK directly, `wb_o_dat` from the buffer.
  - A+1 out of range clears valid.
  - Writes and reset clear valid.
  - Dropping `wb_cyc` does not clear valid.
- Undefined: no buffer; every in-range access takes the WAIT path.

## Test plan
- Reset: assert `i_rst` 2 cycles → `wb_ack`=0, `wb_err`=0, `wb_o_dat`=0000.
- Write 0xBEEF to 0x0010, sel=11, then read 0x0010, WAIT_STATES=2 → write ack 4 cycles after sampling; read returns 0xBEEF. Then write 0x1200 with sel=10 → readback 0x12EF.
- 8-beat burst, adr 0x0020..0x0027, WAIT_STATES=2, first beat sampled at cycle 0:
  - With `WB_RESP_PREFETCH_EN`: acks at cycles 4,6,8,10,12,14,16,18, data matches preload.
  - Without the macro: acks at 4,9,14,...,39.
- Read adr 0x0400 with DEPTH_LOG2=10 → `wb_err` at cycle 1, no ack, `wb_o_dat` unchanged. Read 0x03FF → ack; a following burst beat to 0x0400 → err.
- Prefetch invalidation, macro on: read 0x0030, then write 0x5555 to 0x0031, then read 0x0031 → WAIT path (ack at +4) returning 0x5555, not the stale buffered value.
- Abort: drop `wb_cyc` one cycle into WAIT of a write to 0x0040 → no ack; subsequent read of 0x0040 returns the old value. Assert `i_rst` during WAIT of a read → no ack, FSM back in IDLE.

Source files
------------

// File: rtl/wb_mem_responder.sv
// -----------------------------------------------------------------------------
// wb_mem_responder
//
// Wishbone classic slave in front of a 16-bit word-addressed on-chip memory.
// Serves instruction-cache line refills (8-beat bursts with wb_stb held high)
// and data-side reads/writes. Each strobed beat gets exactly one wb_ack or
// wb_err. WAIT_STATES extra cycles model slow memory.
//
// Optional feature (macro WB_RESP_PREFETCH_EN):
//   A one-entry sequential prefetch buffer. While acking a read of address A,
//   mem[A+1] is captured, so a following read of A+1 is acked one cycle after
//   it is sampled instead of going through the wait path.
//
// Parameters:
//   DEPTH_LOG2  - memory holds 2**DEPTH_LOG2 words (must be < 16)
//   WAIT_STATES - extra cycles before a non-prefetched ack, 0..15
//
// Ports:
//   i_clk     in   clock, rising edge
//   i_rst     in   synchronous active-high reset
//   wb_cyc    in   bus cycle active (also gates ack/err)
//   wb_stb    in   beat strobe
//   wb_adr    in   16-bit word address
//   wb_we     in   1 = write
//   wb_sel    in   byte enables, bit1 = [15:8], bit0 = [7:0]
//   wb_i_dat  in   write data
//   wb_o_dat  out  registered read data, held until the next read ack
//   wb_ack    out  registered one-cycle beat-complete pulse
//   wb_err    out  registered one-cycle beat-failed pulse (out-of-range adr)
// -----------------------------------------------------------------------------
module wb_mem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic [15:0] wb_adr,
    input  logic        wb_we,
    input  logic [1:0]  wb_sel,
    input  logic [15:0] wb_i_dat,
    output logic [15:0] wb_o_dat,
    output logic        wb_ack,
    output logic        wb_err
);

    localparam int AW    = DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } state_t;

    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;

    logic [AW-1:0] adr_q;
    logic          we_q;
    logic [1:0]    sel_q;
    logic [15:0]   dat_q;

    logic          ack_q, err_q;
    logic          req, in_range, pf_hit;
    logic          take_req, do_access, wr_en, rd_en;

    logic [15:0]   mem [DEPTH];

    assign req      = wb_cyc & wb_stb;
    // Any address bit at or above DEPTH_LOG2 set means the word does not exist.
    assign in_range = (wb_adr >> AW) == 16'd0;

    // A reset arriving in the same cycle as the access drops the beat entirely.
    assign wr_en = do_access & we_q & ~i_rst;
    assign rd_en = do_access & ~we_q & ~i_rst;

`ifdef WB_RESP_PREFETCH_EN
    logic          pf_valid;
    logic [AW-1:0] pf_tag;
    logic [15:0]   pf_data;

    assign pf_hit = pf_valid & ~wb_we & (wb_adr[AW-1:0] == pf_tag);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pf_valid <= 1'b0;
            pf_tag   <= '0;
            pf_data  <= '0;
        end else if (wr_en) begin
            // Any write may alias the buffered word, so drop it.
            pf_valid <= 1'b0;
        end else if (state == ST_ACK && !we_q) begin
            // Capture the next sequential word while the master consumes this ack.
            if (adr_q != '1) begin
                pf_valid <= 1'b1;
                pf_tag   <= adr_q + 1'b1;
                pf_data  <= mem[adr_q + 1'b1];
            end else begin
                pf_valid <= 1'b0;
            end
        end
    end
`else
    assign pf_hit = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_next = state;
        cnt_next   = cnt;
        take_req   = 1'b0;
        do_access  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    take_req = 1'b1;
                    if (!in_range) begin
                        state_next = ST_ERR;
                    end else if (pf_hit) begin
                        state_next = ST_ACK;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                // Abort takes priority: a dropped cycle never reaches memory.
                if (!wb_cyc) begin
                    state_next = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    do_access  = 1'b1;
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            ST_ERR:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Request capture; the address is only held while the beat is in flight.
    always_ff @(posedge i_clk) begin
        if (take_req) begin
            adr_q <= wb_adr[AW-1:0];
            we_q  <= wb_we;
            sel_q <= wb_sel;
            dat_q <= wb_i_dat;
        end
    end

    // Memory write port, one enable per byte lane.
    always_ff @(posedge i_clk) begin
        // NOTE: the memory array has no reset; its contents survive i_rst and
        // a reset branch here would prevent RAM inference.
        if (wr_en) begin
            if (sel_q[1]) mem[adr_q][15:8] <= dat_q[15:8];
            if (sel_q[0]) mem[adr_q][7:0]  <= dat_q[7:0];
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            wb_o_dat <= 16'd0;
        end else begin
            ack_q <= (state_next == ST_ACK);
            err_q <= (state_next == ST_ERR);
            if (rd_en) begin
                wb_o_dat <= mem[adr_q];
            end
`ifdef WB_RESP_PREFETCH_EN
            else if (state == ST_IDLE && state_next == ST_ACK) begin
                // Only a prefetch hit goes straight from IDLE to ACK.
                wb_o_dat <= pf_data;
            end
`endif
        end
    end

    assign wb_ack = ack_q & wb_cyc;
    assign wb_err = err_q & wb_cyc;

endmodule
